// File: rtl/memory_unit_pkg.sv
// Shared sizing defaults and address decode for the MEM-stage data memory.
package memory_unit_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int DEPTH_LOG2_DEF = 10;
   localparam int DEPTH          = 1 << DEPTH_LOG2_DEF;

   // Word index is address[log2+1:2]; byte offset and bits above capacity drop out.
   function automatic logic [31:0] word_index(input logic [31:0] address,
                                              input int unsigned log2 = DEPTH_LOG2_DEF);
      return (address >> 2) & ((32'd1 << log2) - 32'd1);
   endfunction

endpackage

// File: rtl/memory_unit.sv
// Word-organised data memory: writes on the rising clk edge, reads combinational.
// Latency: write visible right after its edge, read 0 cycles; no handshake, never stalls.
module memory_unit
   import memory_unit_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       address,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data
);

   localparam int unsigned NUM_WORDS = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_q [NUM_WORDS];
   logic [DEPTH_LOG2-1:0] word_idx;

   assign word_idx = DEPTH_LOG2'(word_index(address, DEPTH_LOG2));

   // Registers rather than a RAM macro so that reset can clear every word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            mem_q[i[DEPTH_LOG2-1:0]] <= '0;
         end
      end else if (MemWrite) begin
         mem_q[word_idx] <= write_data;
      end
   end

   assign read_data = MemRead ? mem_q[word_idx] : '0;

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: expected words queued at write time, popped on readback.
module tb_memory_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] write_data;
   logic [31:0] read_data;

   int total;
   int bad;
   sb_t sb_q[$];
   logic [31:0] model [1024];

   memory_unit dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .write_data (write_data),
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      address    = addr;
      write_data = data;
      MemWrite   = 1'b1;
      MemRead    = 1'b0;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      if (!reset) model[(addr >> 2) & 32'h3FF] = data;
   endtask

   task automatic set_read(input logic [31:0] addr, input logic rd);
      address = addr;
      MemRead = rd;
      #1;
   endtask

   task automatic drain_sb(input string name);
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         set_read(e.addr, 1'b1);
         total++;
         if (read_data !== e.data) begin
            bad++;
            $display("FAIL %s addr=%h: got %h expected %h", name, e.addr, read_data, e.data);
         end
      end
   endtask

   task automatic test_reset();
      set_read(32'h0, 1'b1);
      total++;
      if (read_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: got %h expected 0", read_data);
      end
      @(negedge clk);
      reset = 1'b0;
      do_write(32'h10, 32'hDEADBEEF);
      set_read(32'h10, 1'b1);
      total++;
      if (read_data !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL pre_reset_write: got %h expected deadbeef", read_data);
      end
      // Mid-cycle async assertion: must clear without a clock edge.
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (read_data !== 32'h0) begin
         bad++;
         $display("FAIL async_clear: got %h expected 0", read_data);
      end
      // Write attempted while reset held must be discarded.
      @(negedge clk);
      address    = 32'h20;
      write_data = 32'h5555AAAA;
      MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      set_read(32'h20, 1'b1);
      total++;
      if (read_data !== 32'h0) begin
         bad++;
         $display("FAIL write_in_reset: got %h expected 0", read_data);
      end
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
   endtask

   task automatic test_sweep();
      for (int n = 0; n < 1024; n++) begin
         do_write(32'(4 * n), 32'(n));
         for (int b = 0; b < 4; b++) sb_q.push_back('{addr: 32'(4 * n + b), data: 32'(n)});
      end
      drain_sb("sweep");
   endtask

   task automatic test_byte_steps();
      for (int k = 0; k < 8; k++) do_write(32'(k), 32'(k));
      sb_q.push_back('{addr: 32'h0, data: 32'd3});
      sb_q.push_back('{addr: 32'h4, data: 32'd7});
      drain_sb("byte_steps");
   endtask

   task automatic test_wrap_gate();
      do_write(32'h1000, 32'h12345678);
      sb_q.push_back('{addr: 32'h0, data: 32'h12345678});
      sb_q.push_back('{addr: 32'hFFFF_F000, data: 32'h12345678});
      drain_sb("wrap");
      set_read(32'h0, 1'b0);
      total++;
      if (read_data !== 32'h0) begin
         bad++;
         $display("FAIL read_gate: got %h expected 0", read_data);
      end
   endtask

   task automatic test_rw_same();
      do_write(32'h14, 32'hA);
      @(negedge clk);
      address    = 32'h14;
      MemRead    = 1'b1;
      MemWrite   = 1'b1;
      write_data = 32'hB;
      #1;
      total++;
      if (read_data !== 32'hA) begin
         bad++;
         $display("FAIL rw_before_edge: got %h expected 0000000a", read_data);
      end
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      model[5] = 32'hB;
      total++;
      if (read_data !== 32'hB) begin
         bad++;
         $display("FAIL rw_after_edge: got %h expected 0000000b", read_data);
      end
   endtask

   task automatic test_write_disable();
      MemWrite   = 1'b0;
      write_data = 32'hFFFF_FFFF;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         address = 32'($urandom_range(0, 4095));
         MemRead = e[0];
         @(posedge clk);
      end
      #1;
      for (int i = 0; i < 1024; i++) sb_q.push_back('{addr: 32'(4 * i), data: model[i]});
      drain_sb("write_disable");
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      address    = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      write_data = '0;
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
      #1;
      test_reset();
      test_sweep();
      test_byte_steps();
      test_wrap_gate();
      test_rw_same();
      test_write_disable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
